atomic_ctrl: RTL and testbench

// - Sequences RV32A instructions flagged by main control (atomic=1): LR.W, SC.W, AMO*.W.
// - Sits in the MEM stage between the pipeline and the data-memory port. Owns the LR/SC

---
 rtl/arvi_atomic_pkg.sv | 36 +++
 rtl/atomic_ctrl_amo_alu.sv | 35 +++
 rtl/atomic_ctrl.sv | 163 ++++++++++++++++
 tb/tb_atomic_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_atomic_pkg.sv
// Shared encodings for the RV32A atomic sequencer: funct5 op codes and controller states.
package arvi_atomic_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_RSV_GRAN = 2;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } atomic_state_t;

    function automatic logic is_amo(input logic [4:0] f5);
        case (f5)
            AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/atomic_ctrl_amo_alu.sv
// Combinational read-modify-write datapath: new memory value from old value and rs2.
module amo_alu
    import arvi_atomic_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] mem_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] result_o
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(mem_i) < $signed(rs2_i);
    assign lt_u = mem_i < rs2_i;

    always_comb begin
        result_o = mem_i;
        case (op_i)
            AMO_SWAP: result_o = rs2_i;
            AMO_ADD:  result_o = mem_i + rs2_i;
            AMO_XOR:  result_o = mem_i ^ rs2_i;
            AMO_AND:  result_o = mem_i & rs2_i;
            AMO_OR:   result_o = mem_i | rs2_i;
            AMO_MIN:  result_o = lt_s ? mem_i : rs2_i;
            AMO_MAX:  result_o = lt_s ? rs2_i : mem_i;
            AMO_MINU: result_o = lt_u ? mem_i : rs2_i;
            AMO_MAXU: result_o = lt_u ? rs2_i : mem_i;
            default:  result_o = mem_i;
        endcase
    end

endmodule

// File: rtl/atomic_ctrl.sv
// MEM-stage sequencer for LR.W / SC.W / AMO*.W: owns the LR/SC reservation,
// drives read or read-modify-write bus sequences and stalls the pipeline meanwhile.
module atomic_ctrl
    import arvi_atomic_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned RSV_GRAN = DEF_RSV_GRAN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [4:0]      i_funct5,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_kill,
    input  logic            i_st_snoop,
    input  logic [XLEN-1:0] i_st_addr,
    output logic            o_D_rd,
    output logic            o_D_wr,
    output logic [XLEN-1:0] o_D_addr,
    output logic [XLEN-1:0] o_D_wdata,
    input  logic [XLEN-1:0] i_D_rdata,
    input  logic            i_D_ack,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_misaligned
);

    localparam int unsigned TAG_W = XLEN - RSV_GRAN;

    atomic_state_t   state_q,     state_d;
    logic [XLEN-1:0] addr_q,      addr_d;
    logic [XLEN-1:0] wdata_q,     wdata_d;
    logic [XLEN-1:0] rdata_q,     rdata_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic [4:0]      funct5_q,    funct5_d;
    logic            rsv_valid_q, rsv_valid_d;
    logic [TAG_W-1:0] rsv_tag_q,  rsv_tag_d;

    logic            aligned;
    logic            rsv_hit;
    logic            snoop_hit;
    logic            lr_set;
    logic            sc_q;
    logic [XLEN-1:0] amo_new;

    assign aligned   = (i_addr[1:0] == 2'b00);
    assign sc_q      = (funct5_q == AMO_SC);
    // Whole-vector shifts drop the in-granule byte offset before the tag compare.
    assign rsv_hit   = rsv_valid_q && ((i_addr >> RSV_GRAN) == XLEN'(rsv_tag_q));
    assign snoop_hit = i_st_snoop && ((i_st_addr >> RSV_GRAN) == XLEN'(rsv_tag_q));

    amo_alu #(
        .XLEN (XLEN)
    ) u_amo_alu (
        .op_i     (funct5_q),
        .mem_i    (rdata_q),
        .rs2_i    (wdata_q),
        .result_o (amo_new)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        result_d    = result_q;
        funct5_d    = funct5_q;
        rsv_valid_d = rsv_valid_q;
        rsv_tag_d   = rsv_tag_q;
        lr_set      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d   = i_addr;
                    wdata_d  = i_wdata;
                    funct5_d = i_funct5;
                    if (aligned) begin
                        if (i_funct5 == AMO_LR || is_amo(i_funct5)) begin
                            state_d = ST_RD;
                        end else if (i_funct5 == AMO_SC) begin
                            if (rsv_hit) begin
                                state_d = ST_WR;
                            end else begin
                                result_d = XLEN'(1);
                                state_d  = ST_RESP;
                            end
                        end else begin
                            result_d = '0;
                            state_d  = ST_RESP;
                        end
                    end
                end
            end
            ST_RD: begin
                if (i_D_ack) begin
                    rdata_d = i_D_rdata;
                    if (funct5_q == AMO_LR) begin
                        result_d = i_D_rdata;
                        lr_set   = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (i_D_ack) begin
                    result_d = sc_q ? '0 : rdata_q;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completing LR outranks any clear source in the same cycle.
        if (lr_set) begin
            rsv_valid_d = 1'b1;
            rsv_tag_d   = TAG_W'(addr_q >> RSV_GRAN);
        end else if (i_kill || snoop_hit || (state_q == ST_RESP && sc_q)) begin
            rsv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            result_q    <= '0;
            funct5_q    <= '0;
            rsv_valid_q <= 1'b0;
            rsv_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            result_q    <= result_d;
            funct5_q    <= funct5_d;
            rsv_valid_q <= rsv_valid_d;
            rsv_tag_q   <= rsv_tag_d;
        end
    end

    assign o_D_rd       = (state_q == ST_RD);
    assign o_D_wr       = (state_q == ST_WR);
    assign o_D_addr     = addr_q;
    assign o_D_wdata    = (state_q == ST_WR) ? (sc_q ? wdata_q : amo_new) : '0;
    assign o_done       = (state_q == ST_RESP);
    assign o_result     = result_q;
    assign o_misaligned = (state_q == ST_IDLE) && i_start && !aligned;
    assign o_stall      = ((state_q == ST_IDLE) && i_start && aligned) || o_D_rd || o_D_wr;

endmodule

// File: tb/tb_atomic_ctrl.sv
// Directed plus randomized checks of atomic_ctrl against a transaction-level reference model.
`timescale 1ns/1ps
module tb_atomic_ctrl;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;
    localparam logic [4:0] F_UNDF = 5'b00101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  i_funct5 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        i_kill = 1'b0;
    logic        i_st_snoop = 1'b0;
    logic [31:0] i_st_addr = '0;
    logic        o_D_rd, o_D_wr;
    logic [31:0] o_D_addr, o_D_wdata;
    logic [31:0] i_D_rdata = '0;
    logic        i_D_ack = 1'b0;
    logic        o_stall, o_done, o_misaligned;
    logic [31:0] o_result;

    always #5 clk = ~clk;

    atomic_ctrl #(
        .XLEN     (32),
        .RSV_GRAN (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_funct5     (i_funct5),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_kill       (i_kill),
        .i_st_snoop   (i_st_snoop),
        .i_st_addr    (i_st_addr),
        .o_D_rd       (o_D_rd),
        .o_D_wr       (o_D_wr),
        .o_D_addr     (o_D_addr),
        .o_D_wdata    (o_D_wdata),
        .i_D_rdata    (i_D_rdata),
        .i_D_ack      (i_D_ack),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_misaligned (o_misaligned)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] mem [0:255];
    bit          m_rsv_v = 1'b0;
    logic [31:0] m_rsv_a = '0;
    logic [31:0] last_result;
    int          last_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string pre);
        chk({pre, "_rd"},     32'(o_D_rd),       0);
        chk({pre, "_wr"},     32'(o_D_wr),       0);
        chk({pre, "_addr"},   o_D_addr,          0);
        chk({pre, "_wdata"},  o_D_wdata,         0);
        chk({pre, "_stall"},  32'(o_stall),      0);
        chk({pre, "_done"},   32'(o_done),       0);
        chk({pre, "_result"}, o_result,          0);
        chk({pre, "_mis"},    32'(o_misaligned), 0);
    endtask

    function automatic logic [31:0] amo_ref(input logic [4:0] f, input logic [31:0] m,
                                            input logic [31:0] r);
        int sm, sr;
        sm = m;
        sr = r;
        case (f)
            F_SWAP:  return r;
            F_ADD:   return m + r;
            F_XOR:   return m ^ r;
            F_AND:   return m & r;
            F_OR:    return m | r;
            F_MIN:   return (sm <= sr) ? m : r;
            F_MAX:   return (sm >= sr) ? m : r;
            F_MINU:  return (m <= r) ? m : r;
            F_MAXU:  return (m >= r) ? m : r;
            default: return m;
        endcase
    endfunction

    function automatic bit is_amo_ref(input logic [4:0] f);
        return f inside {F_SWAP, F_ADD, F_XOR, F_AND, F_OR, F_MIN, F_MAX, F_MINU, F_MAXU};
    endfunction

    // One instruction end to end; this bench plays the memory and checks bus behaviour.
    task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input bit kill_busy, input bit rst_wr);
        bit          mis, sc_hit, done, killed;
        logic [31:0] old, exp_res, exp_wv, got_res;
        int          exp_lat, exp_rd, exp_wr, cyc, wcnt, nrd, nwr;

        mis     = (a[1:0] != 2'b00);
        old     = mem[a[9:2]];
        sc_hit  = m_rsv_v && ((m_rsv_a >> 2) == (a >> 2));
        exp_wv  = '0;
        got_res = 'x;
        if (f == F_LR) begin
            exp_res = old; exp_rd = 1; exp_wr = 0; exp_lat = 3 + dly;
        end else if (f == F_SC && sc_hit) begin
            exp_res = 0; exp_rd = 0; exp_wr = 1; exp_wv = wd; exp_lat = 3 + dly;
        end else if (f == F_SC) begin
            exp_res = 1; exp_rd = 0; exp_wr = 0; exp_lat = 2;
        end else if (is_amo_ref(f)) begin
            exp_res = old; exp_rd = 1; exp_wr = 1; exp_wv = amo_ref(f, old, wd);
            exp_lat = 4 + 2 * dly;
        end else begin
            exp_res = 0; exp_rd = 0; exp_wr = 0; exp_lat = 2;
        end

        @(negedge clk);
        i_start   = 1'b1;
        i_funct5  = f;
        i_addr    = a;
        i_wdata   = wd;
        i_D_ack   = 1'($urandom_range(0, 1));
        i_D_rdata = $urandom;
        #1;
        chk("misaligned", 32'(o_misaligned), 32'(mis));
        chk("stall_start", 32'(o_stall), 32'(!mis));
        if (mis) begin
            @(negedge clk);
            i_start = 1'b0;
            i_D_ack = 1'b0;
            #1;
            chk("mis_no_rd", 32'(o_D_rd), 0);
            chk("mis_no_done", 32'(o_done), 0);
            chk("mis_pulse_end", 32'(o_misaligned), 0);
            return;
        end

        cyc = 1; wcnt = 0; nrd = 0; nwr = 0; done = 0; killed = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            i_start   = 1'b0;
            i_D_ack   = 1'b0;
            i_D_rdata = '0;
            i_kill    = 1'b0;
            #1;
            if (o_done) begin
                done    = 1;
                got_res = o_result;
                chk("stall_done", 32'(o_stall), 0);
            end else if (o_D_rd || o_D_wr) begin
                chk("stall_busy", 32'(o_stall), 1);
                chk("addr_stable", o_D_addr, a);
                if (o_D_wr) chk("wdata", o_D_wdata, exp_wv);
                if (rst_wr && o_D_wr) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("rst_in_wr");
                    @(negedge clk);
                    rst_n   = 1'b1;
                    m_rsv_v = 1'b0;
                    return;
                end
                if (kill_busy && !killed) begin
                    i_kill = 1'b1;
                    killed = 1;
                end
                if (wcnt == dly) begin
                    i_D_ack = 1'b1;
                    wcnt    = 0;
                    if (o_D_rd) begin
                        i_D_rdata = mem[a[9:2]];
                        nrd++;
                    end else begin
                        mem[a[9:2]] = o_D_wdata;
                        nwr++;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
        i_kill = 1'b0;
        chk("done_seen", 32'(done), 1);
        chk("result", got_res, exp_res);
        chk("latency", cyc, exp_lat);
        chk("n_rd", nrd, exp_rd);
        chk("n_wr", nwr, exp_wr);

        if (f == F_LR) begin
            m_rsv_v = 1'b1;
            m_rsv_a = a;
        end else if (f == F_SC || killed) begin
            m_rsv_v = 1'b0;
        end
        last_result = got_res;
        last_lat    = cyc;
    endtask

    task automatic snoop(input logic [31:0] sa);
        @(negedge clk);
        i_st_snoop = 1'b1;
        i_st_addr  = sa;
        @(negedge clk);
        i_st_snoop = 1'b0;
        if (m_rsv_v && ((sa >> 2) == (m_rsv_a >> 2))) m_rsv_v = 1'b0;
    endtask

    task automatic kill_pulse();
        @(negedge clk);
        i_kill = 1'b1;
        @(negedge clk);
        i_kill = 1'b0;
        m_rsv_v = 1'b0;
    endtask

    initial begin
        logic [4:0]  ops [0:11];
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] lr_addr;

        ops = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU, F_UNDF};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        lr_addr = 32'h100;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        mem[32'h100 >> 2] = 32'hDEADBEEF;
        do_op(F_LR, 32'h100, 32'h0, 0, 0, 0);
        chk("lr_value", last_result, 32'hDEADBEEF);
        chk("lr_cycles", last_lat, 3);

        do_op(F_SC, 32'h100, 32'h5, 0, 0, 0);
        chk("sc_mem", mem[32'h100 >> 2], 32'h5);
        chk("sc_ok", last_result, 0);
        do_op(F_SC, 32'h100, 32'h7, 0, 0, 0);
        chk("sc_after_sc", last_result, 1);

        do_op(F_LR, 32'h100, 32'h0, 1, 0, 0);
        snoop(32'h102);
        do_op(F_SC, 32'h100, 32'h9, 0, 0, 0);
        chk("sc_snooped", last_result, 1);
        chk("sc_miss_cycles", last_lat, 2);
        chk("sc_snooped_mem", mem[32'h100 >> 2], 32'h5);

        mem[32'h200 >> 2] = 32'h7FFFFFFF;
        do_op(F_ADD, 32'h200, 32'h1, 0, 0, 0);
        chk("amoadd_mem", mem[32'h200 >> 2], 32'h80000000);
        chk("amoadd_old", last_result, 32'h7FFFFFFF);
        chk("amoadd_cycles", last_lat, 4);

        mem[32'h204 >> 2] = 32'hFFFFFFFF;
        do_op(F_MIN, 32'h204, 32'h1, 0, 0, 0);
        chk("amomin_mem", mem[32'h204 >> 2], 32'hFFFFFFFF);
        mem[32'h204 >> 2] = 32'hFFFFFFFF;
        do_op(F_MINU, 32'h204, 32'h1, 0, 0, 0);
        chk("amominu_mem", mem[32'h204 >> 2], 32'h1);

        do_op(F_ADD, 32'h203, 32'h1, 0, 0, 0);
        do_op(F_SWAP, 32'h208, 32'h1234, 5, 0, 0);
        chk("slow_ack_cycles", last_lat, 14);

        do_op(F_LR, 32'h300, 32'h0, 2, 1, 0);
        do_op(F_SC, 32'h300, 32'hAA, 0, 0, 0);
        chk("lr_beats_kill", last_result, 0);
        do_op(F_LR, 32'h100, 32'h0, 0, 0, 0);
        kill_pulse();
        do_op(F_SC, 32'h100, 32'hBB, 0, 0, 0);
        chk("sc_after_kill", last_result, 1);
        do_op(F_MAX, 32'h20C, 32'h3, 1, 1, 0);
        do_op(F_UNDF, 32'h210, 32'h3, 0, 0, 0);

        do_op(F_LR, 32'h110, 32'h0, 0, 0, 0);
        do_op(F_OR, 32'h214, 32'hF0, 1, 0, 1);
        do_op(F_SC, 32'h110, 32'hCC, 0, 0, 0);
        chk("sc_after_reset", last_result, 1);

        for (int n = 0; n < 120; n++) begin
            f = ops[$urandom_range(0, 11)];
            a = 32'h100 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 2) == 0 && m_rsv_v) begin
                f = F_SC;
                a = lr_addr;
            end
            if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
            if (f == F_LR) lr_addr = a;
            do_op(f, a, $urandom, $urandom_range(0, 2), ($urandom_range(0, 9) == 0), 0);
            if ($urandom_range(0, 4) == 0) snoop(32'h100 + $urandom_range(0, 63));
            if ($urandom_range(0, 14) == 0) kill_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
